// File: rtl/noc_params.sv
// Shared NoC router parameters: default buffer geometry, width helper, flit type.
package noc_params;

  localparam int DEF_FLIT_SIZE = 32;
  localparam int DEF_VC_NUM    = 2;
  localparam int DEF_DEPTH     = 8;

  // Ceiling log2; returns the bit count needed to index `value` items.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  typedef logic [DEF_FLIT_SIZE-1:0] flit_t;

endpackage

// File: rtl/flit_fifo.sv
// Single-VC circular flit FIFO. Full/empty come from the occupancy counter,
// and a write to a full FIFO is accepted when a read pops in the same cycle.
module flit_fifo
  import noc_params::*;
#(
  parameter int WIDTH = DEF_FLIT_SIZE,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           data,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [clog2(DEPTH+1)-1:0]  count,
  output logic                       wr_rej,
  output logic                       rd_rej
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wr_ok;
  logic             rd_ok;

  // Accept/reject decisions; reads never see a same-cycle write (no bypass).
  always_comb begin
    rd_ok  = rd_en & ~empty_q;
    wr_ok  = wr_en & (~full_q | rd_ok);
    wr_rej = wr_en & ~wr_ok;
    rd_rej = rd_en & ~rd_ok;
  end

  // Next pointers, occupancy and flags; pointers wrap by explicit compare.
  always_comb begin
    if (rd_ok) begin
      rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
    end else begin
      rptr_d = rptr_q;
    end
    if (wr_ok) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
    end else begin
      wptr_d = wptr_q;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == CNT_W'(0));
  end

  // Control state with asynchronous reset to an empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Flit storage; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wptr_q] <= data;
    end
  end

  assign head  = mem_q[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/input_vc_buffer.sv
// Router input-port buffer: VC_NUM flit FIFOs sharing one write and one read
// port, with per-VC flags/occupancy and a registered protocol-error pulse.
module input_vc_buffer
  import noc_params::*;
#(
  parameter int FLIT_SIZE = DEF_FLIT_SIZE,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int VC_NUM    = DEF_VC_NUM
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [FLIT_SIZE-1:0]                 data_i,
  input  logic                                 write_i,
  input  logic [clog2(VC_NUM)-1:0]             wr_vc_i,
  input  logic                                 read_i,
  input  logic [clog2(VC_NUM)-1:0]             rd_vc_i,
  output logic [FLIT_SIZE-1:0]                 data_o,
  output logic [VC_NUM-1:0]                    full_o,
  output logic [VC_NUM-1:0]                    empty_o,
  output logic [VC_NUM*clog2(DEPTH+1)-1:0]     count_o,
  output logic                                 error_o
);

  localparam int VC_W  = clog2(VC_NUM);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [FLIT_SIZE-1:0] head [VC_NUM];
  logic [VC_NUM-1:0]    wr_en;
  logic [VC_NUM-1:0]    rd_en;
  logic [VC_NUM-1:0]    wr_rej;
  logic [VC_NUM-1:0]    rd_rej;
  logic                 wr_in_range;
  logic                 rd_in_range;
  logic                 error_q, error_d;

  // Compare one bit wider so a power-of-two VC_NUM does not truncate to 0.
  assign wr_in_range = ({1'b0, wr_vc_i} < (VC_W+1)'(VC_NUM));
  assign rd_in_range = ({1'b0, rd_vc_i} < (VC_W+1)'(VC_NUM));

  // Decode the shared write/read ports into per-VC enables.
  always_comb begin
    wr_en = '0;
    rd_en = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      wr_en[v] = write_i & wr_in_range & (wr_vc_i == VC_W'(v));
      rd_en[v] = read_i  & rd_in_range & (rd_vc_i == VC_W'(v));
    end
  end

  // Present the head flit of the selected VC; out-of-range selects give 0.
  always_comb begin
    data_o = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      data_o = (rd_vc_i == VC_W'(v)) ? head[v] : data_o;
    end
  end

  // Any rejected or out-of-range request raises the error next cycle.
  always_comb begin
    error_d = (write_i & ~wr_in_range) | (read_i & ~rd_in_range) |
              (|wr_rej) | (|rd_rej);
  end

  // Error pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error_o = error_q;

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    flit_fifo #(
      .WIDTH (FLIT_SIZE),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en[v]),
      .rd_en  (rd_en[v]),
      .data   (data_i),
      .head   (head[v]),
      .full   (full_o[v]),
      .empty  (empty_o[v]),
      .count  (count_o[v*CNT_W +: CNT_W]),
      .wr_rej (wr_rej[v]),
      .rd_rej (rd_rej[v])
    );
  end

endmodule

// File: tb/tb_input_vc_buffer.sv
// Self-checking bench: DUT a (DEPTH 8, 2 VCs) and DUT b (DEPTH 5, 3 VCs)
// against per-VC queue models.
module tb_input_vc_buffer;
  import noc_params::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT a: FLIT 32, DEPTH 8, VC_NUM 2 (VC_W 1, CNT_W 4)
  logic [31:0] a_data_i, a_data_o;
  logic        a_write, a_read, a_err;
  logic [0:0]  a_wr_vc, a_rd_vc;
  logic [1:0]  a_full, a_empty;
  logic [7:0]  a_count;
  // DUT b: FLIT 32, DEPTH 5, VC_NUM 3 (VC_W 2, CNT_W 3)
  logic [31:0] b_data_i, b_data_o;
  logic        b_write, b_read, b_err;
  logic [1:0]  b_wr_vc, b_rd_vc;
  logic [2:0]  b_full, b_empty;
  logic [8:0]  b_count;

  input_vc_buffer #(.FLIT_SIZE(32), .DEPTH(8), .VC_NUM(2)) u_a (
    .clk(clk), .rst(rst), .data_i(a_data_i), .write_i(a_write), .wr_vc_i(a_wr_vc),
    .read_i(a_read), .rd_vc_i(a_rd_vc), .data_o(a_data_o), .full_o(a_full),
    .empty_o(a_empty), .count_o(a_count), .error_o(a_err));

  input_vc_buffer #(.FLIT_SIZE(32), .DEPTH(5), .VC_NUM(3)) u_b (
    .clk(clk), .rst(rst), .data_i(b_data_i), .write_i(b_write), .wr_vc_i(b_wr_vc),
    .read_i(b_read), .rd_vc_i(b_rd_vc), .data_o(b_data_o), .full_o(b_full),
    .empty_o(b_empty), .count_o(b_count), .error_o(b_err));

  int    n_checks = 0;
  int    n_fail   = 0;
  flit_t mq [6][$];      // model queue for DUT d, VC v at index d*3+v
  flit_t obs_head, exp_head;
  bit    head_valid;
  bit    exp_err;

  function automatic int nvc(input int d); return (d == 0) ? 2 : 3; endfunction
  function automatic int dep(input int d); return (d == 0) ? 8 : 5; endfunction

  function automatic logic [31:0] cnt_of(input int d, input int v);
    if (d == 0) return 32'(a_count[v*4 +: 4]);
    else        return 32'(b_count[v*3 +: 3]);
  endfunction
  function automatic logic full_of(input int d, input int v);
    if (d == 0) return a_full[v];
    else        return b_full[v];
  endfunction
  function automatic logic empty_of(input int d, input int v);
    if (d == 0) return a_empty[v];
    else        return b_empty[v];
  endfunction
  function automatic logic err_of(input int d);
    return (d == 0) ? a_err : b_err;
  endfunction

  // One clock of traffic on DUT d; the model follows the buffer's rules.
  task automatic step(input int d, input bit w, input int wvc, input flit_t wd,
                      input bit r, input int rvc);
    bit racc, wacc;
    if (d == 0) begin
      a_write = w; a_wr_vc = 1'(wvc); a_data_i = wd; a_read = r; a_rd_vc = 1'(rvc);
    end else begin
      b_write = w; b_wr_vc = 2'(wvc); b_data_i = wd; b_read = r; b_rd_vc = 2'(rvc);
    end
    #1;
    obs_head = (d == 0) ? a_data_o : b_data_o;
    racc = r && (rvc < nvc(d)) && (mq[d*3+rvc].size() > 0);
    head_valid = racc;
    exp_head = racc ? mq[d*3+rvc][0] : '0;
    wacc = w && (wvc < nvc(d)) &&
           ((mq[d*3+wvc].size() < dep(d)) || (racc && (rvc == wvc)));
    exp_err = (w && !wacc) || (r && !racc);
    if (racc) void'(mq[d*3+rvc].pop_front());
    if (wacc) mq[d*3+wvc].push_back(wd);
    @(posedge clk); #1;
    a_write = 1'b0; a_read = 1'b0; b_write = 1'b0; b_read = 1'b0;
  endtask

  task automatic test_reset();
    n_checks += 8;
    if (a_empty !== 2'b11)  begin n_fail++; $display("FAIL reset_a_empty got=%b exp=11", a_empty); end
    if (a_full  !== 2'b00)  begin n_fail++; $display("FAIL reset_a_full got=%b exp=00", a_full); end
    if (a_count !== 8'h00)  begin n_fail++; $display("FAIL reset_a_count got=%h exp=00", a_count); end
    if (a_err   !== 1'b0)   begin n_fail++; $display("FAIL reset_a_err got=%b exp=0", a_err); end
    if (b_empty !== 3'b111) begin n_fail++; $display("FAIL reset_b_empty got=%b exp=111", b_empty); end
    if (b_full  !== 3'b000) begin n_fail++; $display("FAIL reset_b_full got=%b exp=000", b_full); end
    if (b_count !== 9'h000) begin n_fail++; $display("FAIL reset_b_count got=%h exp=000", b_count); end
    if (b_err   !== 1'b0)   begin n_fail++; $display("FAIL reset_b_err got=%b exp=0", b_err); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) step(0, 1'b1, 0, 32'h10 + 32'(i), 1'b0, 0);
      else       step(0, 1'b0, 0, 32'h0, 1'b0, 0);
      n_checks += 3;
      if (cnt_of(0, 0) !== 32'(mq[0].size()))
        begin n_fail++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, cnt_of(0, 0), mq[0].size()); end
      if (a_full[0] !== (mq[0].size() == 8))
        begin n_fail++; $display("FAIL fill_full i=%0d got=%b", i, a_full[0]); end
      if (a_err !== exp_err)
        begin n_fail++; $display("FAIL fill_err i=%0d got=%b exp=%b", i, a_err, exp_err); end
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b0, 0, 32'h0, 1'b1, 0);
      n_checks += 2;
      if (obs_head !== 32'h10 + 32'(i))
        begin n_fail++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, obs_head, 32'h10 + 32'(i)); end
      if (cnt_of(0, 0) !== 32'(mq[0].size()))
        begin n_fail++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, cnt_of(0, 0), mq[0].size()); end
    end
    n_checks++;
    if (a_empty[0] !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b exp=1", a_empty[0]); end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 8; i++) step(0, 1'b1, 1, flit_t'($urandom), 1'b0, 0);
    step(0, 1'b1, 1, 32'hAA, 1'b1, 1);
    n_checks += 4;
    if (a_err !== 1'b0)        begin n_fail++; $display("FAIL sfull_err got=%b exp=0", a_err); end
    if (cnt_of(0, 1) !== 32'd8) begin n_fail++; $display("FAIL sfull_count got=%0d exp=8", cnt_of(0, 1)); end
    if (a_full[1] !== 1'b1)    begin n_fail++; $display("FAIL sfull_full got=%b exp=1", a_full[1]); end
    if (!head_valid || obs_head !== exp_head)
      begin n_fail++; $display("FAIL sfull_head got=%h exp=%h", obs_head, exp_head); end
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b0, 0, 32'h0, 1'b1, 1);
      n_checks++;
      if (obs_head !== exp_head) begin n_fail++; $display("FAIL sfull_drain i=%0d got=%h exp=%h", i, obs_head, exp_head); end
    end
    n_checks += 2;
    if (obs_head !== 32'hAA) begin n_fail++; $display("FAIL sfull_last got=%h exp=000000aa", obs_head); end
    if (a_empty[1] !== 1'b1) begin n_fail++; $display("FAIL sfull_empty got=%b exp=1", a_empty[1]); end
  endtask

  task automatic test_simul_empty();
    step(0, 1'b1, 1, 32'h55, 1'b1, 1);
    n_checks += 3;
    if (a_err !== 1'b1)         begin n_fail++; $display("FAIL sempty_err got=%b exp=1", a_err); end
    if (cnt_of(0, 1) !== 32'd1) begin n_fail++; $display("FAIL sempty_count got=%0d exp=1", cnt_of(0, 1)); end
    if (a_empty[1] !== 1'b0)    begin n_fail++; $display("FAIL sempty_empty got=%b exp=0", a_empty[1]); end
    step(0, 1'b0, 0, 32'h0, 1'b1, 1);
    n_checks += 2;
    if (obs_head !== 32'h55) begin n_fail++; $display("FAIL sempty_data got=%h exp=00000055", obs_head); end
    if (a_err !== 1'b0)      begin n_fail++; $display("FAIL sempty_err2 got=%b exp=0", a_err); end
  endtask

  task automatic test_diff_vc();
    for (int i = 0; i < 3; i++) step(0, 1'b1, 0, 32'hC000 + 32'(i), 1'b0, 0);
    for (int i = 0; i < 2; i++) step(0, 1'b1, 1, 32'hD000 + 32'(i), 1'b0, 0);
    step(0, 1'b1, 0, 32'hC0C0, 1'b1, 1);
    n_checks += 4;
    if (cnt_of(0, 0) !== 32'd4) begin n_fail++; $display("FAIL diff_cnt0 got=%0d exp=4", cnt_of(0, 0)); end
    if (cnt_of(0, 1) !== 32'd1) begin n_fail++; $display("FAIL diff_cnt1 got=%0d exp=1", cnt_of(0, 1)); end
    if (a_err !== 1'b0)         begin n_fail++; $display("FAIL diff_err got=%b exp=0", a_err); end
    if (obs_head !== 32'hD000)  begin n_fail++; $display("FAIL diff_head got=%h exp=0000d000", obs_head); end
    for (int v = 0; v < 2; v++) begin
      while (mq[v].size() > 0) begin
        step(0, 1'b0, 0, 32'h0, 1'b1, v);
        n_checks++;
        if (obs_head !== exp_head) begin n_fail++; $display("FAIL diff_drain vc%0d got=%h exp=%h", v, obs_head, exp_head); end
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 60; i++) begin
      bit heavy;
      int wv, rv;
      heavy = ((i / 10) % 2) == 0;
      wv = int'($urandom_range(0, 2));
      rv = ($urandom_range(0, 1) == 0) ? wv : int'($urandom_range(0, 2));
      step(1, $urandom_range(0, 99) < (heavy ? 85 : 40), wv, flit_t'($urandom),
           $urandom_range(0, 99) < (heavy ? 40 : 85), rv);
      n_checks++;
      if (head_valid && obs_head !== exp_head)
        begin n_fail++; $display("FAIL wrap_data i=%0d got=%h exp=%h", i, obs_head, exp_head); end
      n_checks++;
      if (b_err !== exp_err) begin n_fail++; $display("FAIL wrap_err i=%0d got=%b exp=%b", i, b_err, exp_err); end
      for (int v = 0; v < 3; v++) begin
        n_checks += 4;
        if (cnt_of(1, v) !== 32'(mq[3+v].size()))
          begin n_fail++; $display("FAIL wrap_count i=%0d vc%0d got=%0d exp=%0d", i, v, cnt_of(1, v), mq[3+v].size()); end
        if (cnt_of(1, v) > 32'd5)
          begin n_fail++; $display("FAIL wrap_bound i=%0d vc%0d got=%0d max=5", i, v, cnt_of(1, v)); end
        if (full_of(1, v) !== (mq[3+v].size() == 5))
          begin n_fail++; $display("FAIL wrap_full i=%0d vc%0d got=%b", i, v, full_of(1, v)); end
        if (empty_of(1, v) !== (mq[3+v].size() == 0))
          begin n_fail++; $display("FAIL wrap_empty i=%0d vc%0d got=%b", i, v, empty_of(1, v)); end
      end
    end
  endtask

  task automatic test_oob();
    for (int v = 0; v < 3; v++) begin
      while (mq[3+v].size() > 0) begin
        step(1, 1'b0, 0, 32'h0, 1'b1, v);
        n_checks++;
        if (obs_head !== exp_head) begin n_fail++; $display("FAIL oob_drain vc%0d got=%h exp=%h", v, obs_head, exp_head); end
      end
    end
    step(1, 1'b1, 2, 32'hBEEF, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       step(1, 1'b0, 0, 32'h0, 1'b1, 0);   // read empty VC0
        1:       step(1, 1'b0, 0, 32'h0, 1'b1, 3);   // read VC 3 (out of range)
        2:       step(1, 1'b1, 3, 32'h1, 1'b0, 0);   // write VC 3 (out of range)
        default: step(1, 1'b0, 0, 32'h0, 1'b0, 0);   // idle: pulse must end
      endcase
      n_checks += 2;
      if (b_err !== (k < 3)) begin n_fail++; $display("FAIL oob_err k=%0d got=%b exp=%b", k, b_err, k < 3); end
      if (b_count !== 9'b001_000_000) begin n_fail++; $display("FAIL oob_count k=%0d got=%b exp=001000000", k, b_count); end
    end
    step(1, 1'b0, 0, 32'h0, 1'b1, 2);
    n_checks++;
    if (obs_head !== 32'hBEEF) begin n_fail++; $display("FAIL oob_data got=%h exp=0000beef", obs_head); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(0, 1'b1, 0, 32'h70 + 32'(i), 1'b0, 0);
    n_checks++;
    if (cnt_of(0, 0) !== 32'd3) begin n_fail++; $display("FAIL rmid_pre got=%0d exp=3", cnt_of(0, 0)); end
    #2 rst = 1'b1;
    #1;
    for (int q = 0; q < 6; q++) mq[q].delete();
    n_checks += 4;
    if (a_empty !== 2'b11) begin n_fail++; $display("FAIL rmid_empty got=%b exp=11", a_empty); end
    if (a_full  !== 2'b00) begin n_fail++; $display("FAIL rmid_full got=%b exp=00", a_full); end
    if (a_count !== 8'h00) begin n_fail++; $display("FAIL rmid_count got=%h exp=00", a_count); end
    if (a_err   !== 1'b0)  begin n_fail++; $display("FAIL rmid_err got=%b exp=0", a_err); end
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, 1'b1, 0, 32'h99, 1'b0, 0);
    step(0, 1'b0, 0, 32'h0, 1'b1, 0);
    n_checks++;
    if (obs_head !== 32'h99) begin n_fail++; $display("FAIL rmid_after got=%h exp=00000099", obs_head); end
  endtask

  initial begin
    rst = 1'b1;
    a_data_i = '0; a_write = 1'b0; a_wr_vc = '0; a_read = 1'b0; a_rd_vc = '0;
    b_data_i = '0; b_write = 1'b0; b_wr_vc = '0; b_read = 1'b0; b_rd_vc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_fill_drain();
    test_simul_full();
    test_simul_empty();
    test_diff_vc();
    test_wrap();
    test_oob();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
